// File: rtl/ram_sync_param.sv
// ram_sync_param: parametrised single-clock RAM.
// Port A is read/write with a per-bit write mask, port B is read-only with a
// selectable read-during-write result, and a clear sequencer zeroes the
// array after reset and on request. The array itself carries no reset.

module ram_sync_param #(
  parameter int DATA_W         = 4,
  parameter int ADDR_W         = 4,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              csn,
  input  logic              rwn,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] datain,
  input  logic [DATA_W-1:0] wmask,
  output logic [DATA_W-1:0] dataout,
  output logic              dvalid_a,
  input  logic              ren_b,
  input  logic [ADDR_W-1:0] addr_b,
  output logic [DATA_W-1:0] dout_b,
  output logic              dvalid_b,
  input  logic              clr_req,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

  // Masked merge of new write data into an existing word.
  function automatic logic [DATA_W-1:0] merge_word(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [DATA_W-1:0] mask
  );
    return (old_w & ~mask) | (new_w & mask);
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] dataout_q, dataout_d;
  logic [DATA_W-1:0] dout_b_q, dout_b_d;
  logic              dvalid_a_q, dvalid_a_d;
  logic              dvalid_b_q, dvalid_b_d;

  logic              accept_s;
  logic              wr_en_s;
  logic              rd_a_s;
  logic              rd_b_s;
  logic              collide_s;
  logic [DATA_W-1:0] wr_word_s;
  logic [DATA_W-1:0] rd_b_word_s;

  // Access qualification: only in READY, and clr_req takes priority over any access.
  always_comb begin
    accept_s    = (state_q == ST_READY) && !clr_req;
    wr_en_s     = accept_s && !csn && !rwn;
    rd_a_s      = accept_s && !csn && rwn;
    rd_b_s      = accept_s && ren_b;
    wr_word_s   = merge_word(mem[addr], datain, wmask);
    collide_s   = wr_en_s && (addr == addr_b);
    if ((RDW_MODE != 0) && collide_s) begin
      rd_b_word_s = wr_word_s;
    end else begin
      rd_b_word_s = mem[addr_b];
    end
  end

  // Next-state logic for the clear sequencer FSM and its address counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + ADDR_W'(1'b1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_READY;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      ST_READY: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end else begin
          state_d = ST_READY;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // Next values of the read-data and valid registers; data holds when no read is accepted.
  always_comb begin
    dataout_d  = dataout_q;
    dout_b_d   = dout_b_q;
    dvalid_a_d = rd_a_s;
    dvalid_b_d = rd_b_s;
    if (rd_a_s) begin
      dataout_d = mem[addr];
    end else begin
      dataout_d = dataout_q;
    end
    if (rd_b_s) begin
      dout_b_d = rd_b_word_s;
    end else begin
      dout_b_d = dout_b_q;
    end
  end

  // FSM, clear counter and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RESET_STATE;
      cnt_q      <= '0;
      dataout_q  <= '0;
      dout_b_q   <= '0;
      dvalid_a_q <= 1'b0;
      dvalid_b_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dataout_q  <= dataout_d;
      dout_b_q   <= dout_b_d;
      dvalid_a_q <= dvalid_a_d;
      dvalid_b_q <= dvalid_b_d;
    end
  end

  // Array write port: the clear sequencer owns it in CLEAR, port A in READY.
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      mem[cnt_q] <= '0;
    end else if (wr_en_s) begin
      mem[addr] <= wr_word_s;
    end
  end

  assign dataout  = dataout_q;
  assign dout_b   = dout_b_q;
  assign dvalid_a = dvalid_a_q;
  assign dvalid_b = dvalid_b_q;
  assign busy     = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_ram_sync_param.sv
// Directed self-checking bench for ram_sync_param: two default-size
// instances differing only in RDW_MODE share stimulus; a third instance
// covers the wide/deep configuration without clear-on-reset.

module tb_ram_sync_param;

  logic       clk;
  logic       reset_n;
  logic       csn, rwn, ren_b, clr_req;
  logic [3:0] addr, addr_b, datain, wmask;

  logic [3:0] dataout0, dout_b0, dataout1, dout_b1;
  logic       dvalid_a0, dvalid_b0, busy0, dvalid_a1, dvalid_b1, busy1;

  logic       csn2, rwn2, ren_b2, clr_req2;
  logic [5:0] addr2, addr_b2;
  logic [7:0] datain2, wmask2, dataout2, dout_b2;
  logic       dvalid_a2, dvalid_b2, busy2;

  int checks   = 0;
  int failures = 0;

  ram_sync_param #(.DATA_W(4), .ADDR_W(4), .RDW_MODE(0), .CLEAR_ON_RESET(1)) dut0 (
    .clk(clk), .reset_n(reset_n), .csn(csn), .rwn(rwn), .addr(addr),
    .datain(datain), .wmask(wmask), .dataout(dataout0), .dvalid_a(dvalid_a0),
    .ren_b(ren_b), .addr_b(addr_b), .dout_b(dout_b0), .dvalid_b(dvalid_b0),
    .clr_req(clr_req), .busy(busy0)
  );

  ram_sync_param #(.DATA_W(4), .ADDR_W(4), .RDW_MODE(1), .CLEAR_ON_RESET(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .csn(csn), .rwn(rwn), .addr(addr),
    .datain(datain), .wmask(wmask), .dataout(dataout1), .dvalid_a(dvalid_a1),
    .ren_b(ren_b), .addr_b(addr_b), .dout_b(dout_b1), .dvalid_b(dvalid_b1),
    .clr_req(clr_req), .busy(busy1)
  );

  ram_sync_param #(.DATA_W(8), .ADDR_W(6), .RDW_MODE(0), .CLEAR_ON_RESET(0)) dut2 (
    .clk(clk), .reset_n(reset_n), .csn(csn2), .rwn(rwn2), .addr(addr2),
    .datain(datain2), .wmask(wmask2), .dataout(dataout2), .dvalid_a(dvalid_a2),
    .ren_b(ren_b2), .addr_b(addr_b2), .dout_b(dout_b2), .dvalid_b(dvalid_b2),
    .clr_req(clr_req2), .busy(busy2)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr_a(input logic [3:0] a, input logic [3:0] d, input logic [3:0] m);
    csn = 1'b0; rwn = 1'b0; addr = a; datain = d; wmask = m;
    tick();
    csn = 1'b1; rwn = 1'b1;
  endtask

  task automatic rd_a(input string tag, input logic [3:0] a, input logic [3:0] exp);
    csn = 1'b0; rwn = 1'b1; addr = a;
    tick();
    chk(tag, 32'(dataout0), 32'(exp));
    chk({tag, "_dv"}, 32'(dvalid_a0), 32'd1);
    csn = 1'b1;
  endtask

  task automatic rd_all_zero(input string tag);
    for (int i = 0; i < 16; i++) begin
      rd_a(tag, 4'(i), 4'h0);
    end
    tick();
    chk({tag, "_dv_end"}, 32'(dvalid_a0), 32'd0);
  endtask

  task automatic count_busy(input string tag, input int exp_n);
    int n;
    n = 0;
    while (busy0 && n < 40) begin
      tick();
      n++;
    end
    chk(tag, 32'(n), 32'(exp_n));
  endtask

  initial begin
    logic [3:0] held;
    int n;
    reset_n = 1'b0;
    csn = 1'b1; rwn = 1'b1; addr = 4'h0; datain = 4'h0; wmask = 4'h0;
    ren_b = 1'b0; addr_b = 4'h0; clr_req = 1'b0;
    csn2 = 1'b1; rwn2 = 1'b1; addr2 = 6'h0; datain2 = 8'h0; wmask2 = 8'h0;
    ren_b2 = 1'b0; addr_b2 = 6'h0; clr_req2 = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_dataout", 32'(dataout0), 32'h0);
    chk("rst_dout_b", 32'(dout_b0), 32'h0);
    chk("rst_dvalid_a", 32'(dvalid_a0), 32'd0);
    chk("rst_dvalid_b", 32'(dvalid_b0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd1);
    chk("rst_busy2", 32'(busy2), 32'd0);

    // Reset-and-clear: busy for exactly 16 edges, then everything reads zero
    reset_n = 1'b1;
    count_busy("clr_busy_len", 16);
    chk("sweep_busy2", 32'(busy2), 32'd0);
    rd_all_zero("clr_rd");

    // Masked write
    wr_a(4'd3, 4'hF, 4'hF);
    wr_a(4'd3, 4'h0, 4'h5);
    rd_a("mask_rd3", 4'd3, 4'hA);
    wr_a(4'd4, 4'hF, 4'h0);
    rd_a("mask_rd4", 4'd4, 4'h0);

    // Collision: same-edge write and port B read of address 7
    wr_a(4'd7, 4'h2, 4'hF);
    csn = 1'b0; rwn = 1'b0; addr = 4'd7; datain = 4'h9; wmask = 4'hF;
    ren_b = 1'b1; addr_b = 4'd7;
    tick();
    csn = 1'b1; rwn = 1'b1;
    chk("col_old", 32'(dout_b0), 32'h2);
    chk("col_new", 32'(dout_b1), 32'h9);
    chk("col_dvb", 32'(dvalid_b0), 32'd1);
    tick();
    chk("col_after0", 32'(dout_b0), 32'h9);
    chk("col_after1", 32'(dout_b1), 32'h9);
    ren_b = 1'b0;
    tick();
    chk("col_dvb_end", 32'(dvalid_b0), 32'd0);

    // clr_req mid-traffic
    for (int i = 0; i < 16; i++) begin
      wr_a(4'(i), 4'(i + 3), 4'hF);
    end
    rd_a("fill_rd1", 4'd1, 4'h4);
    held = dataout0;
    csn = 1'b0; rwn = 1'b0; addr = 4'd1; datain = 4'h5; wmask = 4'hF;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    chk("clrq_busy", 32'(busy0), 32'd1);
    chk("clrq_nodv", 32'(dvalid_a0), 32'd0);
    rwn = 1'b1; addr = 4'd2; ren_b = 1'b1; addr_b = 4'd2;
    n = 0;
    while (busy0 && n < 40) begin
      tick();
      n++;
      chk("clrq_busy_dva", 32'(dvalid_a0), 32'd0);
      chk("clrq_busy_dvb", 32'(dvalid_b0), 32'd0);
      chk("clrq_hold", 32'(dataout0), 32'(held));
    end
    chk("clrq_busy_len", 32'(n), 32'd16);
    csn = 1'b1; ren_b = 1'b0;
    tick();
    rd_all_zero("clrq_rd");

    // Reset mid-clear
    wr_a(4'd5, 4'hC, 4'hF);
    csn = 1'b0; rwn = 1'b1; addr = 4'd5; ren_b = 1'b1; addr_b = 4'd5;
    tick();
    csn = 1'b1; ren_b = 1'b0;
    chk("pre_rst_a", 32'(dataout0), 32'hC);
    chk("pre_rst_b", 32'(dout_b0), 32'hC);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (7) tick();
    #3;
    reset_n = 1'b0;
    #1;
    chk("mrst_dataout", 32'(dataout0), 32'h0);
    chk("mrst_dout_b", 32'(dout_b0), 32'h0);
    chk("mrst_busy", 32'(busy0), 32'd1);
    #3;
    reset_n = 1'b1;
    count_busy("mrst_busy_len", 16);
    rd_all_zero("mrst_rd");

    // Parameter sweep instance: write 0xA5 to 63, read on both ports together
    csn2 = 1'b0; rwn2 = 1'b0; addr2 = 6'd63; datain2 = 8'hA5; wmask2 = 8'hFF;
    tick();
    rwn2 = 1'b1; ren_b2 = 1'b1; addr_b2 = 6'd63;
    tick();
    csn2 = 1'b1; ren_b2 = 1'b0;
    chk("sweep_a", 32'(dataout2), 32'hA5);
    chk("sweep_b", 32'(dout_b2), 32'hA5);
    chk("sweep_dva", 32'(dvalid_a2), 32'd1);
    chk("sweep_dvb", 32'(dvalid_b2), 32'd1);
    chk("sweep_busy", 32'(busy2), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_sync_param.md
# ram_sync_param

Parametrised synchronous single-clock RAM, the successor to the fixed 16x4 program/data memory. It has three ports:
- **Port A:** read/write, with csn/rwn control and a per-bit write mask.
- **Port B:** independent read-only, with selectable read-during-write behaviour.
- **Clear sequencer:** zeroes the whole array after reset or on request.

It sits between the controller datapath and its program/data storage, replacing the 16x4 instance at default parameters.

## Interface
Parameters:
- DATA_W, 4, word width in bits (>=1)
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W words
- RDW_MODE, 0, port-B read of the address port A writes in the same cycle: 0 = old data, 1 = new (masked-merged) data
- CLEAR_ON_RESET, 1, 1 = run the clear sequence automatically after reset deassertion

Ports:
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- csn  in  1  port A chip select, active low
- rwn  in  1  port A direction: 1 = read, 0 = write
- addr  in  ADDR_W  port A address
- datain  in  DATA_W  port A write data
- wmask  in  DATA_W  port A write mask; bit i = 1 writes datain[i]
- dataout  out  DATA_W  port A registered read data
- dvalid_a  out  1  one-cycle pulse: dataout updated this cycle
- ren_b  in  1  port B read enable, active high
- addr_b  in  ADDR_W  port B address
- dout_b  out  DATA_W  port B registered read data
- dvalid_b  out  1  one-cycle pulse: dout_b updated this cycle
- clr_req  in  1  level-sampled request to zero the whole array
- busy  out  1  clear sequence in progress; all accesses ignored

## Operation
- **Reset (reset_n=0):**
  - dataout=0, dout_b=0, dvalid_a=0, dvalid_b=0, clear counter=0.
  - FSM goes to CLEAR if CLEAR_ON_RESET=1, otherwise READY.
  - busy is driven directly from the FSM state: 1 in CLEAR, 0 in READY.
  - The array itself is not reset; its contents stay undefined until a clear completes.
- **FSM states:** CLEAR and READY.
  - CLEAR: each edge writes 0 to mem[cnt] and increments cnt. On the edge that writes DEPTH-1, cnt wraps to 0 and the FSM moves to READY.
  - READY -> CLEAR on any edge where clr_req=1. An access presented on that same edge is ignored; clr_req has priority.
  - clr_req while in CLEAR is ignored. The sequence does not restart.
- **Port A, READY only:**
  - csn=0, rwn=0 (write): mem[addr] <= (mem[addr] & ~wmask) | (datain & wmask). wmask=0 leaves the word unchanged.
  - csn=0, rwn=1 (read): dataout <= mem[addr]; dvalid_a=1 on the following cycle.
  - csn=1: no operation; dataout holds its value.
- **Port B, READY only:**
  - ren_b=1: dout_b <= mem[addr_b]; dvalid_b=1 on the following cycle.
  - ren_b=0: dout_b holds its value.
- **Collision:** port A write and port B read to the same address on the same edge.
  - RDW_MODE=0: dout_b gets the pre-write word.
  - RDW_MODE=1: dout_b gets the merged post-write word.
  - The write always completes.
- **During CLEAR:** port A and port B requests are dropped; dataout and dout_b hold; dvalid_a and dvalid_b stay 0.
- **Address range:** all ADDR_W-bit addresses are valid. There is no out-of-range case and no wrap logic beyond the clear counter.

## Timing
- Read latency is 1 for both ports. A request sampled at edge k gives data and a valid pulse during cycle k..k+1.
- Write latency is 1. A port A read at edge k+1 of the address written at edge k returns the new data.
- Clear timing (CLEAR_ON_RESET=1): the first rising edge with reset_n=1 is edge 1.
  - Edges 1..DEPTH write addresses 0..DEPTH-1.
  - busy falls after edge DEPTH.
  - The first accepted access is at edge DEPTH+1.
- Clear timing on clr_req sampled at edge k: busy=1 after edge k; zeroing occupies edges k+1..k+DEPTH; the first access is accepted at edge k+DEPTH+1.
- Reset asserted mid-clear: all outputs and cnt reset immediately and asynchronously. With CLEAR_ON_RESET=1 the clear restarts from address 0 after deassertion. With CLEAR_ON_RESET=0 a partial clear is abandoned.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- **Reset-and-clear:** default parameters. Release reset, wait. Required:
  - busy=1 for exactly 16 cycles, then 0.
  - Port A reads of addresses 0..15 all return 0x0, each with a one-cycle dvalid_a.
- **Masked write:** write 0xF to address 3, then write datain=0x0 with wmask=0x5 to address 3, then read address 3 -> dataout=0xA. A write to address 4 with wmask=0x0 leaves the word at 0x0.
- **Collision:** address 7 holds 0x2. Same edge: port A writes 0x9 (wmask=0xF) to address 7 and port B reads address 7. Required:
  - RDW_MODE=0: dout_b=0x2.
  - RDW_MODE=1: dout_b=0x9.
  - A subsequent port B read returns 0x9 in both modes.
- **clr_req mid-traffic:** fill memory with a pattern. Assert clr_req for 1 cycle together with a port A write of 0x5 to address 1. Required:
  - The write is dropped and busy is high for 16 cycles.
  - Reads issued while busy produce no dvalid pulse and dataout holds.
  - Every address reads 0x0 afterwards.
- **Reset mid-clear:** assert reset_n=0 at clear cycle 8 for half a cycle. Required:
  - Outputs go to 0 immediately.
  - After release, busy lasts a full 16 cycles and all addresses read 0x0.
- **Parameter sweep:** DATA_W=8, ADDR_W=6, CLEAR_ON_RESET=0. Required:
  - busy=0 straight out of reset.
  - A write of 0xA5 to address 63, read back on both ports in the same cycle, returns 0xA5 on both ports one cycle later.
